gpio_shift_out: RTL
===================

Name: gpio_shift_out

Overview:
Downstream consumer of the 32-bit GPIO output register word. It serialises that word onto an external serial-in/parallel-out shift register chain (74HC595-style), producing three signals: clock, data and latch. A new transfer starts automatically whenever the word differs from the last value sent, or when software forces a refresh. This is how GPIO outputs reach board pins beyond the FPGA's direct I/O budget.

Parameters:
DATA_WIDTH, 32, width of the GPIO word and number of bits shifted per transfer (>=2)
CLK_DIV, 4, system-clock cycles per sr_clk half-period (>=1)
MSB_FIRST, 1, 1 = bit DATA_WIDTH-1 shifted first; 0 = bit 0 shifted first

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-low reset
gpio_in  input  DATA_WIDTH  GPIO output word from the GPIO output register
force_update  input  1  single-cycle pulse; request retransmission even if the word is unchanged
sr_clk  output  1  shift clock to the external register; data is sampled on its rising edge
sr_data  output  1  serial data to the external register
sr_latch  output  1  storage-register latch pulse, active-high
busy  output  1  high while a transfer is in progress
update_count  output  16  number of completed transfers; wraps from 0xFFFF to 0x0000

Behaviour:
- Reset (rst=0): asynchronous, takes effect immediately.
  - sr_clk, sr_data, sr_latch, busy = 0; update_count = 0.
  - Shift register = 0; last_sent = 0.
  - pending = 1, so one transfer is guaranteed after reset release (external chain state is unknown at power-up).
- States: IDLE, SHIFT, LATCH.
- IDLE, trigger: trigger = pending OR force_update OR (gpio_in != last_sent). On a trigger in cycle T0:
  - load shift register and last_sent from gpio_in;
  - clear pending;
  - enter SHIFT.
- Transfer timing (W = DATA_WIDTH, D = CLK_DIV):
  - From T0+1: busy=1.
  - Bit k (k=0..W-1): sr_data is valid from cycle T0+1+2kD for 2D cycles. sr_clk is 0 for the first D cycles of that window and 1 for the last D cycles.
  - At T0+1+2WD: sr_clk=0, sr_data=0, enter LATCH. sr_latch=1 for D cycles.
  - At T0+1+(2W+1)D: sr_latch=0, busy=0, update_count increments, return to IDLE.
  - Total busy duration: (2W+1)D cycles.
- Bit order:
  - MSB_FIRST=1: bit k = captured word bit W-1-k.
  - MSB_FIRST=0: bit k = captured word bit k.
- The captured value is frozen for the whole transfer. gpio_in changes during busy do not disturb it.
- Coalescing:
  - After returning to IDLE, the block compares gpio_in with last_sent again. Any number of intermediate changes during busy collapse into one follow-up transfer carrying the current gpio_in.
  - A force_update during busy sets pending, so exactly one further transfer follows, regardless of how many pulses arrived.
  - force_update in the same cycle a trigger is accepted is consumed by that transfer and does not set pending.
- Back-to-back transfers: the earliest re-trigger is the first IDLE cycle after busy falls, so there is a minimum of 1 IDLE cycle between transfers.
- While IDLE: sr_clk, sr_data and sr_latch are all held at 0.
- Reset mid-transfer: outputs go to 0 immediately. After release, a full transfer of the current gpio_in follows (pending=1). A partial transfer is never latched.
- CLK_DIV=1 is legal: sr_clk toggles every cycle and the latch pulse is 1 cycle.
- All outputs are registered; no combinational path from any input to any output.

Test Plan:
All scenarios use DATA_WIDTH=32 and CLK_DIV=2 unless stated; busy lasts 130 cycles.
1. Release rst with gpio_in=0x0000_0000 -> one transfer: 32 sr_clk rising edges all sampling 0, one 2-cycle sr_latch pulse, busy high for 130 cycles, then update_count=1 and no further activity.
2. Set gpio_in=0xA5A5_0F0F -> bits sampled on sr_clk rising edges read 1,0,1,0,0,1,0,1,... (MSB first) and reconstruct 0xA5A5_0F0F exactly; update_count=2.
3. During a busy transfer, drive gpio_in to 0x1, then 0x2, then 0x3 -> exactly one follow-up transfer, carrying 0x0000_0003, starting the first IDLE cycle after busy falls.
4. force_update pulse with gpio_in unchanged -> one transfer of the same value. Three force_update pulses during that busy period -> exactly one further transfer; update_count advances by 2 in total.
5. Assert rst while shifting bit 10 -> sr_clk, sr_data, sr_latch and busy are 0 with no clock edge, and update_count=0. After release, one full transfer of the current gpio_in, and no sr_latch pulse appears before its 32nd bit.
6. MSB_FIRST=0, CLK_DIV=1, gpio_in=0x0000_0001 -> first sampled bit is 1 and the remaining 31 are 0; busy lasts 65 cycles; sr_latch is high for 1 cycle.

Source files
------------

// File: rtl/gpio_shift_out.sv
// Serialises the GPIO output word onto a 74HC595-style shift/latch chain,
// retransmitting whenever the word changes or software forces a refresh.
module gpio_shift_out #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CLK_DIV    = 4,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] gpio_in,
  input  logic                  force_update,
  output logic                  sr_clk,
  output logic                  sr_data,
  output logic                  sr_latch,
  output logic                  busy,
  output logic [15:0]           update_count
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(DATA_WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic [DATA_WIDTH-1:0] last_sent, last_nxt;
  logic                  pending, pending_nxt;
  logic [DIV_W-1:0]      div_cnt, div_nxt;
  logic                  phase, phase_nxt;
  logic [BIT_W-1:0]      bit_cnt, bit_nxt;
  logic                  sr_clk_nxt, sr_data_nxt, sr_latch_nxt, busy_nxt;
  logic [15:0]           count_nxt;

  logic                  trigger;
  logic                  first_bit;
  logic                  next_bit;
  logic [DATA_WIDTH-1:0] shreg_shift;

  // Bit presented next is always at the outgoing end of the shift register.
  always_comb begin
    trigger     = pending || force_update || (gpio_in != last_sent);
    first_bit   = MSB_FIRST ? gpio_in[DATA_WIDTH-1] : gpio_in[0];
    shreg_shift = MSB_FIRST ? {shreg[DATA_WIDTH-2:0], 1'b0}
                            : {1'b0, shreg[DATA_WIDTH-1:1]};
    next_bit    = MSB_FIRST ? shreg_shift[DATA_WIDTH-1] : shreg_shift[0];
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    last_nxt     = last_sent;
    pending_nxt  = pending;
    div_nxt      = div_cnt;
    phase_nxt    = phase;
    bit_nxt      = bit_cnt;
    sr_clk_nxt   = sr_clk;
    sr_data_nxt  = sr_data;
    sr_latch_nxt = sr_latch;
    busy_nxt     = busy;
    count_nxt    = update_count;

    unique case (state)
      IDLE: begin
        sr_clk_nxt   = 1'b0;
        sr_data_nxt  = 1'b0;
        sr_latch_nxt = 1'b0;
        busy_nxt     = 1'b0;
        if (trigger) begin
          state_nxt   = SHIFT;
          shreg_nxt   = gpio_in;
          last_nxt    = gpio_in;
          pending_nxt = 1'b0;
          div_nxt     = '0;
          phase_nxt   = 1'b0;
          bit_nxt     = '0;
          busy_nxt    = 1'b1;
          sr_data_nxt = first_bit;
        end
      end

      SHIFT: begin
        if (force_update) pending_nxt = 1'b1;
        if (div_cnt == DIV_LAST) begin
          div_nxt = '0;
          if (!phase) begin
            phase_nxt  = 1'b1;
            sr_clk_nxt = 1'b1;
          end else begin
            phase_nxt  = 1'b0;
            sr_clk_nxt = 1'b0;
            if (bit_cnt == BIT_LAST) begin
              state_nxt    = LATCH;
              sr_data_nxt  = 1'b0;
              sr_latch_nxt = 1'b1;
            end else begin
              bit_nxt     = bit_cnt + 1'b1;
              shreg_nxt   = shreg_shift;
              sr_data_nxt = next_bit;
            end
          end
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end

      LATCH: begin
        if (force_update) pending_nxt = 1'b1;
        if (div_cnt == DIV_LAST) begin
          div_nxt      = '0;
          state_nxt    = IDLE;
          sr_latch_nxt = 1'b0;
          busy_nxt     = 1'b0;
          count_nxt    = update_count + 16'd1;
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Pending starts set so the unknown external chain is refreshed after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      shreg        <= '0;
      last_sent    <= '0;
      pending      <= 1'b1;
      div_cnt      <= '0;
      phase        <= 1'b0;
      bit_cnt      <= '0;
      sr_clk       <= 1'b0;
      sr_data      <= 1'b0;
      sr_latch     <= 1'b0;
      busy         <= 1'b0;
      update_count <= '0;
    end else begin
      state        <= state_nxt;
      shreg        <= shreg_nxt;
      last_sent    <= last_nxt;
      pending      <= pending_nxt;
      div_cnt      <= div_nxt;
      phase        <= phase_nxt;
      bit_cnt      <= bit_nxt;
      sr_clk       <= sr_clk_nxt;
      sr_data      <= sr_data_nxt;
      sr_latch     <= sr_latch_nxt;
      busy         <= busy_nxt;
      update_count <= count_nxt;
    end
  end

endmodule
